// File: rtl/tile_serializer.sv
// Tile serializer: captures a ROWS x COLS tile and emits it one element per
// handshake in row-major order, with zero-bubble back-to-back tile capture.
module tile_serializer #(
    parameter  int DW   = 11,
    parameter  int ROWS = 2,
    parameter  int COLS = 4,
    localparam int N    = ROWS * COLS,
    localparam int IW   = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_valid,
    output logic          i_ready,
    input  logic [DW-1:0] i_tile [ROWS][COLS],
    input  logic [3:0]    i_tag,
    output logic          o_valid,
    input  logic          o_ready,
    output logic [DW-1:0] o_data,
    output logic [IW-1:0] o_idx,
    output logic          o_last,
    output logic [3:0]    o_tag,
    output logic [15:0]   o_tile_cnt
);

    typedef enum logic {
        IDLE,
        SEND
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [IW-1:0] r_idx;
    logic [DW-1:0] r_buf [N];
    logic [3:0]    r_tag;
    logic [15:0]   r_tile_cnt;

    logic w_send;
    logic w_last;
    logic w_rdy;
    logic w_cap;
    logic w_hs_last;
    logic w_adv;

    // i_ready is gated by rst so nothing is accepted while reset is held
    always_comb begin
        w_send      = (r_state == SEND);
        w_last      = w_send && (r_idx == IW'(N - 1));
        w_rdy       = rst && (!w_send || (o_ready && w_last));
        w_cap       = i_valid && w_rdy;
        w_hs_last   = w_send && o_ready && w_last;
        w_adv       = w_send && o_ready && !w_last;
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE: if (w_cap) w_state_nxt = SEND;
            SEND: if (w_hs_last && !w_cap) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= IDLE;
        else      r_state <= w_state_nxt;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_idx      <= '0;
            r_tag      <= '0;
            r_tile_cnt <= '0;
            for (int k = 0; k < N; k++) r_buf[k] <= '0;
        end else begin
            if (w_cap) begin
                r_idx <= '0;
                r_tag <= i_tag;
                for (int r = 0; r < ROWS; r++)
                    for (int c = 0; c < COLS; c++)
                        r_buf[r*COLS+c] <= i_tile[r][c];
            end else if (w_adv) begin
                r_idx <= r_idx + IW'(1);
            end
            if (w_hs_last) r_tile_cnt <= r_tile_cnt + 16'd1;
        end
    end

    assign i_ready    = w_rdy;
    assign o_valid    = w_send;
    assign o_data     = w_send ? r_buf[r_idx] : '0;
    assign o_idx      = w_send ? r_idx : '0;
    assign o_last     = w_last;
    assign o_tag      = w_send ? r_tag : '0;
    assign o_tile_cnt = r_tile_cnt;

endmodule

// File: tb/tb_tile_serializer.sv
// Directed bench for tile_serializer: single tile, back-to-back, backpressure,
// reset mid-tile, counter wrap and input isolation.
module tb_tile_serializer;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_valid;
    logic        i_ready;
    logic [10:0] tile [2][4];
    logic [3:0]  i_tag;
    logic        o_valid;
    logic        o_ready;
    logic [10:0] o_data;
    logic [2:0]  o_idx;
    logic        o_last;
    logic [3:0]  o_tag;
    logic [15:0] o_tile_cnt;

    int passed = 0;
    int total  = 0;

    // Row-major image of i_tile[r][c] = 16*r + c
    logic [10:0] exp_d [8] = '{11'd0, 11'd1, 11'd2, 11'd3,
                               11'd16, 11'd17, 11'd18, 11'd19};
    logic        pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

    tile_serializer dut (
        .clk        (clk),
        .rst        (rst),
        .i_valid    (i_valid),
        .i_ready    (i_ready),
        .i_tile     (tile),
        .i_tag      (i_tag),
        .o_valid    (o_valid),
        .o_ready    (o_ready),
        .o_data     (o_data),
        .o_idx      (o_idx),
        .o_last     (o_last),
        .o_tag      (o_tag),
        .o_tile_cnt (o_tile_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic set_tile(input int base);
        for (int r = 0; r < 2; r++)
            for (int c = 0; c < 4; c++)
                tile[r][c] = 11'(base + 16 * r + c);
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int eidx;
        int j;
        rst = 1'b0;
        i_valid = 1'b0;
        o_ready = 1'b0;
        i_tag = 4'h0;
        set_tile(0);

        // Reset state
        tick();
        tick();
        chk("rst_i_ready", i_ready, 0);
        chk("rst_o_valid", o_valid, 0);
        chk("rst_cnt", o_tile_cnt, 0);
        chk("rst_o_data", o_data, 0);
        rst = 1'b1;
        #1;
        chk("post_rst_i_ready", i_ready, 1);

        // Single tile with input isolation
        set_tile(0);
        i_tag = 4'h5;
        i_valid = 1'b1;
        o_ready = 1'b1;
        tick();
        i_valid = 1'b0;
        for (int r = 0; r < 2; r++)
            for (int c = 0; c < 4; c++) tile[r][c] = 11'h7FF;
        i_tag = 4'hF;
        for (int k = 0; k < 8; k++) begin
            chk("t1_valid", o_valid, 1);
            chk("t1_data", o_data, exp_d[k]);
            chk("t1_idx", o_idx, k);
            chk("t1_last", o_last, k == 7);
            chk("t1_tag", o_tag, 4'h5);
            chk("t1_i_ready", i_ready, k == 7);
            tick();
        end
        chk("t1_idle_valid", o_valid, 0);
        chk("t1_idle_data", o_data, 0);
        chk("t1_idle_idx", o_idx, 0);
        chk("t1_idle_tag", o_tag, 0);
        chk("t1_cnt", o_tile_cnt, 1);
        chk("t1_idle_ready", i_ready, 1);

        // Back-to-back: three tiles, no gap
        set_tile(100);
        i_tag = 4'h1;
        i_valid = 1'b1;
        tick();
        for (int t = 0; t < 3; t++) begin
            for (int k = 0; k < 8; k++) begin
                if (k == 0) begin
                    if (t < 2) begin
                        set_tile(100 * (t + 2));
                        i_tag = 4'(t + 2);
                    end else begin
                        i_valid = 1'b0;
                    end
                    #1;
                end
                chk("b2b_valid", o_valid, 1);
                chk("b2b_data", o_data, 100 * (t + 1) + exp_d[k]);
                chk("b2b_idx", o_idx, k);
                chk("b2b_tag", o_tag, t + 1);
                chk("b2b_i_ready", i_ready, k == 7);
                tick();
            end
        end
        chk("b2b_end_valid", o_valid, 0);
        chk("b2b_cnt", o_tile_cnt, 4);

        // Backpressure 1,0,0,1 repeating
        set_tile(0);
        i_tag = 4'h5;
        i_valid = 1'b1;
        tick();
        i_valid = 1'b0;
        eidx = 0;
        j = 0;
        while (eidx < 8 && j < 64) begin
            o_ready = pat[j % 4];
            #1;
            chk("bp_valid", o_valid, 1);
            chk("bp_data", o_data, exp_d[eidx]);
            chk("bp_idx", o_idx, eidx);
            chk("bp_i_ready", i_ready, o_ready && eidx == 7);
            tick();
            if (o_ready) eidx++;
            j++;
        end
        chk("bp_done", eidx, 8);
        chk("bp_end_valid", o_valid, 0);
        chk("bp_cnt", o_tile_cnt, 5);

        // Reset mid-tile
        o_ready = 1'b1;
        i_tag = 4'h5;
        i_valid = 1'b1;
        tick();
        i_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk("mr_idx", o_idx, k);
            tick();
        end
        rst = 1'b0;
        #1;
        chk("mr_valid", o_valid, 0);
        chk("mr_cnt", o_tile_cnt, 0);
        chk("mr_i_ready", i_ready, 0);
        chk("mr_data", o_data, 0);
        tick();
        tick();
        rst = 1'b1;
        #1;
        chk("mr_rel_valid", o_valid, 0);
        tick();
        chk("mr_idle_valid", o_valid, 0);
        set_tile(64);
        i_tag = 4'hA;
        i_valid = 1'b1;
        tick();
        i_valid = 1'b0;
        for (int k = 0; k < 8; k++) begin
            chk("mr_new_idx", o_idx, k);
            chk("mr_new_data", o_data, 64 + exp_d[k]);
            chk("mr_new_tag", o_tag, 4'hA);
            tick();
        end
        chk("mr_new_cnt", o_tile_cnt, 1);

        // Counter wrap via preload
        force dut.r_tile_cnt = 16'hFFFE;
        #1;
        release dut.r_tile_cnt;
        tick();
        chk("wrap_preload", o_tile_cnt, 16'hFFFE);
        i_tag = 4'h3;
        i_valid = 1'b1;
        for (int k = 0; k < 17; k++) begin
            if (k == 9) i_valid = 1'b0;
            tick();
            if (k == 8) chk("wrap_ffff", o_tile_cnt, 16'hFFFF);
        end
        chk("wrap_zero", o_tile_cnt, 0);
        chk("wrap_idle", o_valid, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/tile_serializer.md
TILE_SERIALIZER -- requirements
Module: tile_serializer

Interface
REQ-001 SHALL have parameter DW, default 11, width of each tile element.
REQ-002 SHALL have parameter ROWS, default 2, tile rows.
REQ-003 SHALL have parameter COLS, default 4, tile columns; N = ROWS*COLS, IW = clog2(N), default 3.
REQ-004 SHALL have port clk, input, 1, single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port i_valid, input, 1, upstream tile valid.
REQ-007 SHALL have port i_ready, output, 1, block accepts a tile this cycle.
REQ-008 SHALL have port i_tile, input, DW x [ROWS][COLS] unpacked array, tile from the upstream compute stage.
REQ-009 SHALL have port i_tag, input, 4, tile identifier carried with the tile.
REQ-010 SHALL have port o_valid, input, 1 -- corrected: output, 1, element valid.
REQ-011 SHALL have port o_ready, input, 1, downstream accepts the element.
REQ-012 SHALL have port o_data, output, DW, current element.
REQ-013 SHALL have port o_idx, output, IW, row-major index of o_data (r*COLS+c).
REQ-014 SHALL have port o_last, output, 1, high on element N-1.
REQ-015 SHALL have port o_tag, output, 4, tag of the tile being sent.
REQ-016 SHALL have port o_tile_cnt, output, 16, count of fully transmitted tiles.

Function
REQ-017 SHALL implement FSM states IDLE and SEND; a tile is captured (i_tile, i_tag registered) on i_valid && i_ready.
REQ-018 SHALL drive i_ready = 1 in IDLE; in SEND, i_ready = o_ready && o_last (combinational path o_ready->i_ready permitted).
REQ-019 IDLE -> SEND on capture, idx <= 0; no capture keeps IDLE.
REQ-020 In SEND, o_valid SHALL be 1, o_data = buf[idx/COLS][idx%COLS], o_idx = idx, o_last = (idx == N-1), o_tag = captured tag.
REQ-021 On o_valid && o_ready with o_last = 0, idx SHALL increment by 1; with o_ready = 0, all outputs SHALL hold stable.
REQ-022 On last-element handshake with i_valid = 1, SHALL capture the new tile, stay in SEND, idx <= 0 (zero-bubble, N cycles per tile sustained).
REQ-023 On last-element handshake with i_valid = 0, SHALL go to IDLE.
REQ-024 Latency SHALL be 1 cycle: first element valid the cycle after capture.
REQ-025 o_data, o_idx, o_last, o_tag SHALL be 0 whenever o_valid = 0.
REQ-026 o_tile_cnt SHALL increment on each last-element handshake, wrapping 16'hFFFF -> 0.
REQ-027 i_tile/i_tag changes while not captured SHALL not affect buffered data.

Reset
REQ-028 rst low SHALL immediately force state IDLE, idx 0, o_valid 0, o_tile_cnt 0, tag/buffer 0, data outputs 0.
REQ-029 i_ready SHALL be 0 while rst is low; 1 from the first cycle after rst deasserts.
REQ-030 Reset mid-tile SHALL discard the partial tile; no further elements of it emitted after release.

Verification
REQ-031 Single tile: rst released, i_tile[r][c] = 16*r+c, i_tag = 4'h5, o_ready = 1 -> 8 elements 0,1,2,3,16,17,18,19, o_idx 0..7, o_last only on 19, o_tag 5, o_tile_cnt 1.
REQ-032 Back-to-back: 3 tiles with i_valid held high, o_ready = 1 -> 24 consecutive o_valid cycles, no gap, i_ready pulses on o_idx 7 only, o_tile_cnt 3.
REQ-033 Backpressure: o_ready toggled 1,0,0,1 repeating -> o_data stable across stalls, sequence identical to REQ-031, i_ready 0 until last handshake.
REQ-034 Reset mid-tile: rst low after 3 elements for 2 cycles -> o_valid 0 immediately, o_tile_cnt 0, next tile with tag 4'hA starts at o_idx 0.
REQ-035 Counter wrap: force 65536 tiles (or preload via shortened sim) -> o_tile_cnt reads 0 after the 65536th last handshake.
REQ-036 Input isolation: change i_tile to all 11'h7FF one cycle after capture -> output still the captured values.
